// File: rtl/gpu_axil_regs.sv
// AXI4-lite control/status register file for the GPU: frame configuration,
// frame_start launch pulse, busy/done tracking from frame_end, and level irq.
module gpu_axil_regs #(
  parameter int          AXI_ADDR_WIDTH = 8,
  parameter int          ADDR_WIDTH     = 32,
  parameter logic [31:0] ID_VALUE       = 32'h4750_5531
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [AXI_ADDR_WIDTH-1:0] awaddr,
  input  logic [2:0]                awprot,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [31:0]               wdata,
  input  logic [3:0]                wstrb,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,
  input  logic [AXI_ADDR_WIDTH-1:0] araddr,
  input  logic [2:0]                arprot,
  input  logic                      arvalid,
  output logic                      arready,
  output logic [31:0]               rdata,
  output logic [1:0]                rresp,
  output logic                      rvalid,
  input  logic                      rready,
  input  logic                      frame_end,
  output logic                      frame_start,
  output logic [31:0]               triangles_count,
  output logic [ADDR_WIDTH-1:0]     base_addr_vertex,
  output logic [ADDR_WIDTH-1:0]     base_addr_color,
  output logic                      irq
);

  typedef enum logic [2:0] {
    REG_CTRL, REG_STAT, REG_TRI, REG_VTX, REG_COL, REG_FCNT, REG_ID, REG_NONE
  } reg_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                  busy, done, irq_en;
  logic [31:0]           tri_count, frame_cnt;
  logic [ADDR_WIDTH-1:0] vtx_base, col_base;

  reg_e        wr_reg, rd_reg;
  logic        wr_fire, rd_fire, start_fire, done_clr, cfg_wr;
  logic [1:0]  wr_resp, rd_resp;
  logic [31:0] rd_val;

  // Protection bits and address bits outside [4:2] carry no meaning here.
  logic unused;
  assign unused = ^{awprot, arprot, awaddr, araddr};

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] strb);
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++)
      if (strb[i]) res[8*i +: 8] = data[8*i +: 8];
    return res;
  endfunction

  // NOTE: every signal assigned in this block gets a value before any branch, so no latch can form.
  always_comb begin
    wr_reg     = reg_e'(awaddr[4:2]);
    rd_reg     = reg_e'(araddr[4:2]);
    awready    = awvalid & wvalid & ~bvalid & ~rst;
    wready     = awready;
    arready    = arvalid & ~rvalid & ~rst;
    wr_fire    = awready;
    rd_fire    = arready;
    start_fire = wr_fire && wr_reg == REG_CTRL && wstrb[0] && wdata[0] && !busy;
    done_clr   = wr_fire && wr_reg == REG_STAT && wstrb[0] && wdata[1];
    cfg_wr     = wr_fire && !busy;

    wr_resp = RESP_OKAY;
    if (wr_reg == REG_NONE) wr_resp = RESP_SLVERR;
    else if (busy && (wr_reg == REG_TRI || wr_reg == REG_VTX || wr_reg == REG_COL))
      wr_resp = RESP_SLVERR;

    rd_resp = RESP_OKAY;
    rd_val  = '0;
    case (rd_reg)
      REG_CTRL: rd_val = {30'd0, irq_en, 1'b0};
      REG_STAT: rd_val = {30'd0, done, busy};
      REG_TRI:  rd_val = tri_count;
      REG_VTX:  rd_val = 32'(vtx_base);
      REG_COL:  rd_val = 32'(col_base);
      REG_FCNT: rd_val = frame_cnt;
      REG_ID:   rd_val = ID_VALUE;
      default:  rd_resp = RESP_SLVERR;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      bvalid      <= 1'b0;
      bresp       <= RESP_OKAY;
      rvalid      <= 1'b0;
      rresp       <= RESP_OKAY;
      rdata       <= '0;
      frame_start <= 1'b0;
      irq         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      irq_en      <= 1'b0;
      tri_count   <= '0;
      vtx_base    <= '0;
      col_base    <= '0;
      frame_cnt   <= '0;
    end else begin
      frame_start <= start_fire;
      irq         <= done & irq_en;

      if (wr_fire) begin
        bvalid <= 1'b1;
        bresp  <= wr_resp;
      end else if (bvalid && bready) begin
        bvalid <= 1'b0;
      end

      if (rd_fire) begin
        rvalid <= 1'b1;
        rdata  <= rd_val;
        rresp  <= rd_resp;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end

      if (wr_fire && wr_reg == REG_CTRL && wstrb[0]) irq_en <= wdata[1];

      // Config is frozen while a frame runs so the pipeline sees stable inputs.
      if (cfg_wr) begin
        case (wr_reg)
          REG_TRI: tri_count <= merge(tri_count, wdata, wstrb);
          REG_VTX: vtx_base  <= ADDR_WIDTH'(merge(32'(vtx_base), wdata, wstrb));
          REG_COL: col_base  <= ADDR_WIDTH'(merge(32'(col_base), wdata, wstrb));
          default: ;
        endcase
      end

      // A completing frame outranks a same-cycle clear of DONE.
      if (frame_end) begin
        done      <= 1'b1;
        frame_cnt <= frame_cnt + 32'd1;
      end else if (done_clr) begin
        done <= 1'b0;
      end

      if (start_fire)     busy <= 1'b1;
      else if (frame_end) busy <= 1'b0;
    end
  end

  assign triangles_count  = tri_count;
  assign base_addr_vertex = vtx_base;
  assign base_addr_color  = col_base;

endmodule
